// File: rtl/spi_cmd_rx_pkg.sv
// ---------------------------------------------------------------------------
// spi_cmd_rx_pkg
// Shared definitions for the SPI command receiver slice:
//   - receive FSM state encoding
//   - status byte layout shifted out on MISO at chip-select fall
//   - default FIFO depth and synchroniser length
//   - helper that builds the status byte from the overflow flag and the
//     number of free FIFO entries
// ---------------------------------------------------------------------------
package spi_cmd_rx_pkg;

   typedef enum logic {
      SPI_RX_STATE_IDLE  = 1'b0,
      SPI_RX_STATE_SHIFT = 1'b1
   } spiRxState_t;

   localparam int DEFAULT_FIFO_DEPTH  = 16;
   localparam int DEFAULT_SYNC_STAGES = 2;

   // Status byte: bit 7 is the sticky overflow flag, bits 6..0 carry the
   // free-entry count saturated to what seven bits can hold.
   localparam int STATUS_OVF_BIT  = 7;
   localparam int STATUS_FREE_W   = 7;
   localparam int STATUS_FREE_MAX = (1 << STATUS_FREE_W) - 1;

   // Builds the status byte; deep FIFOs report "127 or more" free entries.
   function automatic logic [7:0] statusByte(input logic ovf, input int unsigned freeCnt);
      logic [7:0]               status;
      logic [STATUS_FREE_W-1:0] sat;
      if (freeCnt > STATUS_FREE_MAX) begin
         sat = STATUS_FREE_W'(STATUS_FREE_MAX);
      end else begin
         sat = freeCnt[STATUS_FREE_W-1:0];
      end
      status                 = {1'b0, sat};
      status[STATUS_OVF_BIT] = ovf;
      return status;
   endfunction

endpackage

// File: rtl/spi_cmd_rx_byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Show-ahead synchronous FIFO. The head entry is always visible on o_data
// (zero when empty). Pointers carry an extra wrap bit so full and empty
// fall out of a pointer compare. A push while full is accepted only when a
// pop happens in the same cycle.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_push       write i_data this cycle
//   i_data       data to write
//   i_pop        advance the read pointer (ignored when empty)
//   o_data       head of queue
//   o_full       all entries occupied
//   o_empty      no entries occupied
//   o_level      registered entry count
// ---------------------------------------------------------------------------
module byte_fifo
   import spi_cmd_rx_pkg::*;
#(
   parameter int DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int WIDTH = 8,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [LW-1:0]    o_level
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_rdPtr;
   logic [AW:0]      r_wrPtr;
   logic [LW-1:0]    r_level;
   logic             w_popEn;
   logic             w_pushEn;

   // Same index with differing wrap bits means the writer has lapped the
   // reader once: full. Identical pointers mean empty.
   assign o_empty  = (r_rdPtr == r_wrPtr);
   assign o_full   = (r_rdPtr[AW] != r_wrPtr[AW]) && (r_rdPtr[AW-1:0] == r_wrPtr[AW-1:0]);
   assign w_popEn  = i_pop & ~o_empty;
   assign w_pushEn = i_push & (~o_full | w_popEn);
   assign o_data   = o_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];
   assign o_level  = r_level;

   // Storage is write-only from the clocked side; when full with a
   // simultaneous pop the write lands in the slot being vacated.
   always_ff @(posedge clk) begin
      if (w_pushEn) begin
         r_mem[r_wrPtr[AW-1:0]] <= i_data;
      end
   end

   // Pointers and the level counter move together; the level is kept as
   // its own register so it is a clean flop output for the status byte.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdPtr <= '0;
         r_wrPtr <= '0;
         r_level <= '0;
      end else begin
         if (w_pushEn) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_popEn) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_pushEn, w_popEn})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/spi_cmd_rx.sv
// ---------------------------------------------------------------------------
// spi_cmd_rx
// SPI mode-0 slave byte receiver feeding a show-ahead byte FIFO. SCK, MOSI
// and CS_N are synchronised into clk and edge-detected; bytes are assembled
// MSB first and queued. At each CS fall a status byte {overflow, free
// entries} is loaded and shifted out on MISO so the host can pace writes.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   spi_sck          SPI clock (asynchronous)
//   spi_mosi         SPI data in (asynchronous)
//   spi_cs_n         chip select, active low (asynchronous)
//   spi_miso         status bit out
//   out_byte         FIFO head, valid while out_ready
//   out_ready        FIFO non-empty
//   next             single-cycle pop request
//   clear_overflow   single-cycle clear of the sticky overflow flag
//   overflow         a completed byte was dropped because the FIFO was full
//   fifo_level       current FIFO entry count
// ---------------------------------------------------------------------------
module spi_cmd_rx
   import spi_cmd_rx_pkg::*;
#(
   parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          spi_sck,
   input  logic                          spi_mosi,
   input  logic                          spi_cs_n,
   output logic                          spi_miso,
   output logic [7:0]                    out_byte,
   output logic                          out_ready,
   input  logic                          next,
   input  logic                          clear_overflow,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [SYNC_STAGES-1:0] r_sckSync;
   logic [SYNC_STAGES-1:0] r_mosiSync;
   logic [SYNC_STAGES-1:0] r_csnSync;
   logic                   r_sckDly;
   logic                   r_csnDly;
   spiRxState_t            r_state;
   spiRxState_t            w_stateNext;
   logic [2:0]             r_bitCtr;
   logic [6:0]             r_rxShift;
   logic [7:0]             r_txShift;
   logic                   r_overflow;

   logic                   w_sck;
   logic                   w_mosi;
   logic                   w_csn;
   logic                   w_sckRise;
   logic                   w_sckFall;
   logic                   w_csFall;
   logic                   w_csRise;
   logic                   w_load;
   logic                   w_abort;
   logic                   w_rxEn;
   logic                   w_txEn;
   logic                   w_push;
   logic [7:0]             w_pushByte;
   logic [7:0]             w_status;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_drop;
   logic [LW-1:0]          w_level;

   // Synchroniser chains. Reset presets them to the idle bus (SCK low,
   // CS_N high) so that leaving reset never looks like an SCK edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sckSync  <= '0;
         r_mosiSync <= '0;
         r_csnSync  <= '1;
         r_sckDly   <= 1'b0;
         r_csnDly   <= 1'b1;
      end else begin
         r_sckSync  <= {r_sckSync[SYNC_STAGES-2:0], spi_sck};
         r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], spi_mosi};
         r_csnSync  <= {r_csnSync[SYNC_STAGES-2:0], spi_cs_n};
         r_sckDly   <= w_sck;
         r_csnDly   <= w_csn;
      end
   end

   assign w_sck      = r_sckSync[SYNC_STAGES-1];
   assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
   assign w_csn      = r_csnSync[SYNC_STAGES-1];
   assign w_sckRise  = w_sck & ~r_sckDly;
   assign w_sckFall  = ~w_sck & r_sckDly;
   assign w_csFall   = ~w_csn & r_csnDly;
   assign w_csRise   = w_csn & ~r_csnDly;
   assign w_pushByte = {r_rxShift, w_mosi};
   assign w_status   = statusByte(r_overflow, 32'(FIFO_DEPTH) - 32'(w_level));

   // Receive FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= SPI_RX_STATE_IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next state and datapath strobes. A CS rise ends the frame and masks
   // any SCK edge seen in the same cycle; the eighth rising edge pushes the
   // byte formed from the seven stored bits plus the bit arriving now.
   always_comb begin
      w_stateNext = r_state;
      w_load      = 1'b0;
      w_abort     = 1'b0;
      w_rxEn      = 1'b0;
      w_txEn      = 1'b0;
      w_push      = 1'b0;
      unique case (r_state)
         SPI_RX_STATE_IDLE: begin
            if (w_csFall) begin
               w_stateNext = SPI_RX_STATE_SHIFT;
               w_load      = 1'b1;
            end
         end
         SPI_RX_STATE_SHIFT: begin
            if (w_csRise) begin
               w_stateNext = SPI_RX_STATE_IDLE;
               w_abort     = 1'b1;
            end else begin
               w_rxEn = w_sckRise;
               w_txEn = w_sckFall;
               w_push = w_sckRise && (r_bitCtr == 3'd7);
            end
         end
         default: w_stateNext = SPI_RX_STATE_IDLE;
      endcase
   end

   // Shift registers and bit counter. The 3-bit counter wraps to zero on
   // the byte-completing edge; an aborted frame just clears it, dropping
   // the partial byte. MISO is the transmit MSB, so zeros follow once the
   // status byte is fully shifted.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bitCtr  <= '0;
         r_rxShift <= '0;
         r_txShift <= '0;
      end else begin
         if (w_load) begin
            r_bitCtr  <= '0;
            r_txShift <= w_status;
         end
         if (w_abort) begin
            r_bitCtr <= '0;
         end
         if (w_rxEn) begin
            r_rxShift <= {r_rxShift[5:0], w_mosi};
            r_bitCtr  <= r_bitCtr + 1'b1;
         end
         if (w_txEn) begin
            r_txShift <= {r_txShift[6:0], 1'b0};
         end
      end
   end

   assign spi_miso = r_txShift[7];

   // A completed byte is lost only when the FIFO is full and no pop frees
   // a slot in the same cycle.
   assign w_drop = w_push & w_full & ~(next & ~w_empty);

   // Sticky overflow; a new drop beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (clear_overflow) begin
         r_overflow <= 1'b0;
      end
   end

   assign overflow = r_overflow;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_pushByte),
      .i_pop   (next),
      .o_data  (out_byte),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_level (w_level)
   );

   assign out_ready  = ~w_empty;
   assign fifo_level = w_level;

endmodule

// File: tb/tb_spi_cmd_rx.sv
// ---------------------------------------------------------------------------
// tb_spi_cmd_rx
// Directed bench for spi_cmd_rx. Stimulus pushes each byte the DUT should
// accept into a scoreboard queue; a monitor pops and compares every time a
// pop is presented to the DUT. Directed checks cover levels, flags and the
// MISO status byte.
// ---------------------------------------------------------------------------
module tb_spi_cmd_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       spi_sck;
   logic       spi_mosi;
   logic       spi_cs_n;
   logic       spi_miso;
   logic [7:0] out_byte;
   logic       out_ready;
   logic       next;
   logic       manualNext;
   logic       autoNext;
   logic       clear_overflow;
   logic       overflow;
   logic [4:0] fifo_level;

   bit         autoPop;
   int         testsRun;
   int         failCount;
   logic [7:0] expQ[$];
   logic [7:0] misoByte;

   assign next = manualNext | autoNext;

   spi_cmd_rx #(
      .FIFO_DEPTH  (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .spi_sck        (spi_sck),
      .spi_mosi       (spi_mosi),
      .spi_cs_n       (spi_cs_n),
      .spi_miso       (spi_miso),
      .out_byte       (out_byte),
      .out_ready      (out_ready),
      .next           (next),
      .clear_overflow (clear_overflow),
      .overflow       (overflow),
      .fifo_level     (fifo_level)
   );

   // 10-unit clock; SPI half period is four clk periods.
   initial forever #5 clk = ~clk;

   // Hard stop so a stuck bench still reports.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic waitClk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic csLow();
      spi_cs_n = 1'b0;
      waitClk(4);
   endtask

   task automatic csHigh();
      waitClk(4);
      spi_cs_n = 1'b1;
      waitClk(6);
   endtask

   // Shifts nBits of b MSB first in mode 0, capturing MISO just before each
   // rising edge. With popAtPush the controller pop is timed to land on the
   // same clk edge as the eighth bit's push.
   task automatic sendBits(input logic [7:0] b, input int nBits, input bit popAtPush,
                           output logic [7:0] miso);
      logic [7:0] sh;
      sh   = b;
      miso = 8'h00;
      for (int i = 0; i < nBits; i++) begin
         spi_mosi = sh[7];
         sh       = {sh[6:0], 1'b0};
         waitClk(4);
         miso    = {miso[6:0], spi_miso};
         spi_sck = 1'b1;
         if (popAtPush && i == 7) begin
            waitClk(2);
            manualNext = 1'b1;
            waitClk(1);
            manualNext = 1'b0;
            waitClk(1);
         end else begin
            waitClk(4);
         end
         spi_sck = 1'b0;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input bit expectPush, input bit popAtPush,
                                output logic [7:0] miso);
      if (expectPush) expQ.push_back(b);
      sendBits(b, 8, popAtPush, miso);
   endtask

   task automatic popManual();
      manualNext = 1'b1;
      waitClk(1);
      manualNext = 1'b0;
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while ((expQ.size() != 0 || out_ready) && n < budget) begin
         waitClk(1);
         n++;
      end
      checkOutput("drainQueue", 32'(expQ.size()), 32'd0);
      checkOutput("drainReady", 32'(out_ready), 32'd0);
   endtask

   // Scoreboard monitor: every presented pop must match the queue head.
   initial begin
      logic [7:0] expByte;
      forever begin
         @(negedge clk);
         #2;
         if (next && out_ready) begin
            if (expQ.size() == 0) begin
               testsRun++;
               failCount++;
               $display("[TB] FAIL popOrder: got 0x%0h, expected no byte", out_byte);
            end else begin
               expByte = expQ.pop_front();
               checkOutput("popOrder", 32'(out_byte), 32'(expByte));
            end
         end
      end
   end

   // Controller-style consumer: pop one cycle after seeing data, then idle.
   initial begin
      autoNext = 1'b0;
      forever begin
         @(negedge clk);
         if (autoPop && out_ready) begin
            @(negedge clk);
            autoNext = 1'b1;
            @(negedge clk);
            autoNext = 1'b0;
            @(negedge clk);
         end
      end
   end

   initial begin
      testsRun       = 0;
      failCount      = 0;
      autoPop        = 1'b0;
      manualNext     = 1'b0;
      clear_overflow = 1'b0;
      spi_sck        = 1'b0;
      spi_mosi       = 1'b0;
      spi_cs_n       = 1'b1;
      reset          = 1'b1;
      waitClk(3);

      // Reset values
      checkOutput("rstReady", 32'(out_ready), 32'd0);
      checkOutput("rstByte", 32'(out_byte), 32'd0);
      checkOutput("rstLevel", 32'(fifo_level), 32'd0);
      checkOutput("rstOverflow", 32'(overflow), 32'd0);
      checkOutput("rstMiso", 32'(spi_miso), 32'd0);
      reset = 1'b0;
      waitClk(4);

      // Two bytes in one frame, manual pops
      csLow();
      applyStimulus(8'hA5, 1'b1, 1'b0, misoByte);
      checkOutput("t1Status", 32'(misoByte), 32'h10);
      checkOutput("t1Ready", 32'(out_ready), 32'd1);
      checkOutput("t1Head", 32'(out_byte), 32'hA5);
      applyStimulus(8'h3C, 1'b1, 1'b0, misoByte);
      csHigh();
      checkOutput("t1Level", 32'(fifo_level), 32'd2);
      popManual();
      checkOutput("t1Head2", 32'(out_byte), 32'h3C);
      popManual();
      checkOutput("t1Empty", 32'(out_ready), 32'd0);
      checkOutput("t1Level0", 32'(fifo_level), 32'd0);

      // Controller-style consumption of three bytes
      autoPop = 1'b1;
      csLow();
      applyStimulus(8'h01, 1'b1, 1'b0, misoByte);
      applyStimulus(8'h02, 1'b1, 1'b0, misoByte);
      applyStimulus(8'h03, 1'b1, 1'b0, misoByte);
      csHigh();
      waitDrain(300);
      autoPop = 1'b0;
      waitClk(4);

      // Partial byte discarded, then a full byte
      csLow();
      sendBits(8'hFF, 5, 1'b0, misoByte);
      csHigh();
      checkOutput("t3Partial", 32'(out_ready), 32'd0);
      csLow();
      applyStimulus(8'h7E, 1'b1, 1'b0, misoByte);
      csHigh();
      checkOutput("t3Level", 32'(fifo_level), 32'd1);
      checkOutput("t3Head", 32'(out_byte), 32'h7E);
      popManual();
      checkOutput("t3Empty", 32'(fifo_level), 32'd0);

      // Fill past full: 16 accepted, 17th dropped
      csLow();
      for (int i = 0; i < 17; i++) begin
         applyStimulus(8'(8'h10 + i), (i < 16), 1'b0, misoByte);
         if (i == 0) checkOutput("t4StatusEmpty", 32'(misoByte), 32'h10);
      end
      csHigh();
      checkOutput("t4Level", 32'(fifo_level), 32'd16);
      checkOutput("t4Overflow", 32'(overflow), 32'd1);
      csLow();
      applyStimulus(8'h00, 1'b0, 1'b0, misoByte);
      csHigh();
      checkOutput("t4StatusFull", 32'(misoByte), 32'h80);
      checkOutput("t4LevelHeld", 32'(fifo_level), 32'd16);
      clear_overflow = 1'b1;
      waitClk(1);
      clear_overflow = 1'b0;
      checkOutput("t4Cleared", 32'(overflow), 32'd0);
      popManual();
      checkOutput("t4Level15", 32'(fifo_level), 32'd15);
      csLow();
      applyStimulus(8'h55, 1'b1, 1'b0, misoByte);
      csHigh();
      checkOutput("t4StatusOne", 32'(misoByte), 32'h01);
      checkOutput("t4Refull", 32'(fifo_level), 32'd16);

      // Push coinciding with pop while full
      csLow();
      applyStimulus(8'h66, 1'b1, 1'b1, misoByte);
      csHigh();
      checkOutput("t5Level", 32'(fifo_level), 32'd16);
      checkOutput("t5Overflow", 32'(overflow), 32'd0);
      autoPop = 1'b1;
      waitDrain(1000);
      autoPop = 1'b0;
      waitClk(4);

      // Reset mid-byte with CS held low
      csLow();
      sendBits(8'hC3, 4, 1'b0, misoByte);
      reset = 1'b1;
      waitClk(2);
      checkOutput("t6RstReady", 32'(out_ready), 32'd0);
      checkOutput("t6RstByte", 32'(out_byte), 32'd0);
      checkOutput("t6RstLevel", 32'(fifo_level), 32'd0);
      checkOutput("t6RstOverflow", 32'(overflow), 32'd0);
      checkOutput("t6RstMiso", 32'(spi_miso), 32'd0);
      reset = 1'b0;
      waitClk(10);
      checkOutput("t6NoPush", 32'(fifo_level), 32'd0);
      csHigh();
      csLow();
      applyStimulus(8'h5A, 1'b1, 1'b0, misoByte);
      csHigh();
      checkOutput("t6Level", 32'(fifo_level), 32'd1);
      autoPop = 1'b1;
      waitDrain(300);
      autoPop = 1'b0;

      checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
